// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Issues operations to a clocked ALU and returns results/flags with
//           carry chaining; valid/ready request and response channels.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH       = 32,
    parameter int OP_W        = 4,
    parameter int OP_MAX      = 9,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    input  logic [OP_W-1:0]  ReqOp,
    input  logic             ReqCin,
    input  logic             ReqUseCarry,
    output logic [WIDTH-1:0] ALUA,
    output logic [WIDTH-1:0] ALUB,
    output logic [OP_W-1:0]  ALUControl,
    output logic             ALUFlagIn,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [3:0]       ALUFlags,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspResult,
    output logic [3:0]       RspFlags,
    output logic             RspErr,
    output logic             Busy,
    output logic [CNT_W-1:0] OpCount
);

    localparam logic [OP_W-1:0] c_OP_MAX = OP_W'(OP_MAX);
    localparam logic [3:0]      c_LAT    = 4'(ALU_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_lat_cnt;
    logic       r_carry;
    logic       w_legal;

    assign w_legal = (ReqOp <= c_OP_MAX);

    // All outputs are registered; ReqReady/Busy track the next state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= 4'd0;
            r_carry    <= 1'b0;
            ReqReady   <= 1'b1;
            ALUA       <= '0;
            ALUB       <= '0;
            ALUControl <= '0;
            ALUFlagIn  <= 1'b0;
            RspValid   <= 1'b0;
            RspResult  <= '0;
            RspFlags   <= 4'd0;
            RspErr     <= 1'b0;
            Busy       <= 1'b0;
            OpCount    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ReqValid) begin
                        ReqReady <= 1'b0;
                        Busy     <= 1'b1;
                        if (w_legal) begin
                            ALUA       <= ReqA;
                            ALUB       <= ReqB;
                            ALUControl <= ReqOp;
                            ALUFlagIn  <= ReqUseCarry ? r_carry : ReqCin;
                            r_lat_cnt  <= c_LAT;
                            r_state    <= S_WAIT;
                        end else begin
                            // Illegal opcode: answer with an error, ALU untouched.
                            RspResult <= '0;
                            RspFlags  <= 4'd0;
                            RspErr    <= 1'b1;
                            RspValid  <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt != 4'd0) begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end else begin
                        RspResult <= ALUResult;
                        RspFlags  <= ALUFlags;
                        RspErr    <= 1'b0;
                        r_carry   <= ALUFlags[1];
                        RspValid  <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        OpCount  <= OpCount + 1'b1;
                        ReqReady <= 1'b1;
                        Busy     <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    ReqReady <= 1'b1;
                    Busy     <= 1'b0;
                    RspValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed self-checking bench for alu_issue_ctrl with a 1-cycle ALU.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             Clk;
    logic             Rst_n;
    logic             ReqValid;
    logic             ReqReady;
    logic [WIDTH-1:0] ReqA;
    logic [WIDTH-1:0] ReqB;
    logic [3:0]       ReqOp;
    logic             ReqCin;
    logic             ReqUseCarry;
    logic [WIDTH-1:0] ALUA;
    logic [WIDTH-1:0] ALUB;
    logic [3:0]       ALUControl;
    logic             ALUFlagIn;
    logic [WIDTH-1:0] ALUResult;
    logic [3:0]       ALUFlags;
    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspResult;
    logic [3:0]       RspFlags;
    logic             RspErr;
    logic             Busy;
    logic [CNT_W-1:0] OpCount;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [CNT_W-1:0] exp_cnt;

    alu_issue_ctrl #(
        .WIDTH(WIDTH), .OP_W(4), .OP_MAX(9), .ALU_LATENCY(1), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA(ReqA), .ReqB(ReqB), .ReqOp(ReqOp),
        .ReqCin(ReqCin), .ReqUseCarry(ReqUseCarry),
        .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl), .ALUFlagIn(ALUFlagIn),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspResult(RspResult), .RspFlags(RspFlags), .RspErr(RspErr),
        .Busy(Busy), .OpCount(OpCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // One-stage ALU model: op0 = A+B+FlagIn, anything else = A^B.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        if (op == 4'd0) begin
            s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r = a ^ b;
            c = 1'b0;
            v = 1'b0;
        end
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_ff @(posedge Clk) begin
        {ALUFlags, ALUResult} <= alu_f(ALUA, ALUB, ALUControl, ALUFlagIn);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic cin, input logic usec);
        ReqValid = 1'b1; ReqA = a; ReqB = b; ReqOp = op; ReqCin = cin; ReqUseCarry = usec;
        @(posedge Clk); #1;
        ReqValid = 1'b0; ReqA = '1; ReqB = '1; ReqOp = 4'd0; ReqCin = 1'b0; ReqUseCarry = 1'b0;
    endtask

    // Counts rising edges from the current point until RspValid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!RspValid && lat < 30) begin
            @(posedge Clk); #1;
            lat++;
        end
        if (!RspValid) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_rsp();
        @(posedge Clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        chk("rsp_drop", RspValid, 0);
        chk("opcount", OpCount, exp_cnt);
        chk("ready_back", ReqReady, 1);
    endtask

    int lat;
    int t_prev;
    int t_now;

    initial begin
        Rst_n = 1'b0; ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0;
        ReqCin = 1'b0; ReqUseCarry = 1'b0; RspReady = 1'b1;
        exp_cnt = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", ReqReady, 1);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_alua", ALUA, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_cnt", OpCount, 0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // T1: basic add
        issue(32'd15, 32'd1, 4'd0, 1'b1, 1'b0);
        chk("t1_alua", ALUA, 15);
        chk("t1_alub", ALUB, 1);
        chk("t1_ctl", ALUControl, 0);
        chk("t1_fin", ALUFlagIn, 1);
        chk("t1_busy", Busy, 1);
        chk("t1_ready", ReqReady, 0);
        wait_rsp(lat);
        chk("t1_lat", lat, 2);
        chk("t1_res", RspResult, 17);
        chk("t1_flags", RspFlags, 4'b0000);
        chk("t1_err", RspErr, 0);
        finish_rsp();

        // T2: carry chain
        issue(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        chk("t2a_res", RspResult, 0);
        chk("t2a_flags", RspFlags, 4'b0110);
        finish_rsp();
        issue(32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        chk("t2b_fin", ALUFlagIn, 1);
        wait_rsp(lat);
        chk("t2b_res", RspResult, 1);
        chk("t2b_flags", RspFlags, 4'b0000);
        finish_rsp();

        // T3: illegal opcode leaves ALU outputs and carry alone
        issue(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        finish_rsp();
        issue(32'h1234_5678, 32'h9, 4'hA, 1'b0, 1'b0);
        chk("t3_rspv_next", RspValid, 1);
        chk("t3_alua", ALUA, 32'hFFFF_FFFF);
        chk("t3_alub", ALUB, 1);
        chk("t3_ctl", ALUControl, 0);
        chk("t3_err", RspErr, 1);
        chk("t3_res", RspResult, 0);
        chk("t3_flags", RspFlags, 0);
        finish_rsp();
        issue(32'd5, 32'd6, 4'd3, 1'b0, 1'b1);
        chk("t3_carry_kept", ALUFlagIn, 1);
        wait_rsp(lat);
        chk("t3_xor_res", RspResult, 3);
        chk("t3_xor_err", RspErr, 0);
        finish_rsp();

        // T4: response backpressure with a competing request
        RspReady = 1'b0;
        issue(32'd1, 32'd2, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        ReqValid = 1'b1; ReqA = 32'd99; ReqB = 32'd99; ReqOp = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("t4_hold_v", RspValid, 1);
            chk("t4_hold_res", RspResult, 3);
            chk("t4_ready", ReqReady, 0);
            chk("t4_cnt", OpCount, exp_cnt);
        end
        chk("t4_alua", ALUA, 1);
        ReqValid = 1'b0;
        RspReady = 1'b1;
        finish_rsp();

        // T5: async reset mid-WAIT
        issue(32'd7, 32'd8, 4'd0, 1'b0, 1'b0);
        chk("t5_busy", Busy, 1);
        #1 Rst_n = 1'b0;
        #1;
        chk("t5_ready", ReqReady, 1);
        chk("t5_rspv", RspValid, 0);
        chk("t5_alua", ALUA, 0);
        chk("t5_cnt", OpCount, 0);
        exp_cnt = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        issue(32'd2, 32'd3, 4'd0, 1'b0, 1'b0);
        wait_rsp(lat);
        chk("t5_lat", lat, 2);
        chk("t5_res", RspResult, 5);
        finish_rsp();

        // T6: back-to-back ops, counter wraps at CNT_W=2
        ReqValid = 1'b1; ReqA = 32'd1; ReqB = 32'd1; ReqOp = 4'd0;
        ReqCin = 1'b0; ReqUseCarry = 1'b0;
        t_prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(lat);
            t_now = cyc;
            chk("t6_res", RspResult, 2);
            if (t_prev >= 0) chk("t6_spacing", t_now - t_prev, 4);
            t_prev = t_now;
            finish_rsp();
        end
        ReqValid = 1'b0;
        chk("t6_final_cnt", OpCount, 2);
        repeat (4) @(posedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
